// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key schedule tables, widths and rotate/parity helpers
package des_pkg;

    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;
    localparam logic [3:0] LAST_BEAT = 4'(ROUNDS - 1);

    // Entry i is the DES bit number (1 = MSB) feeding output bit i+1.
    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Bit r-1 set means round r rotates by 2; rounds 1, 2, 9 and 16 rotate by 1.
    localparam logic [15:0] SHIFT_SCHED = 16'h7EFC;

    // Rotate both 28-bit halves of C||D by 1 or 2, left or right.
    function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic right,
                                           input logic two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (right) begin
            c = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
            d = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
        end else begin
            c = two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
            d = two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    // Every key byte must carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [63:0] key);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ok = ok & (^key[b*8 +: 8]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/des_pc1.sv
// rtl/des_pc1.sv - DES permuted choice 1, 64-bit key to 56-bit C||D
// Ports: key_in [63:0] (bit 63 = DES bit 1), cd [55:0] (bit 55 = PC-1 bit 1).
module des_pc1
    import des_pkg::*;
(
    input  logic [63:0] key_in,
    output logic [55:0] cd
);

    for (genvar i = 0; i < 56; i++) begin : g_perm
        localparam int SRC = 64 - PC1_TBL[i];
        assign cd[55 - i] = key_in[SRC];
    end

    // Byte parity bits are not part of the key material.
    logic unused_parity;
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8], key_in[0]};

endmodule

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - DES permuted choice 2, 56-bit C||D to 48-bit round key
// Ports: cd [55:0] (bit 55 = C bit 1), subkey [47:0] (bit 47 = PC-2 bit 1).
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] subkey
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_perm
        localparam int SRC = 56 - PC2_TBL[i];
        assign subkey[47 - i] = cd[SRC];
    end

    // C||D bits 9, 18, 22, 25, 35, 38, 43 and 54 are dropped by PC-2.
    logic unused_dropped;
    assign unused_dropped = ^{cd[47], cd[38], cd[34], cd[31],
                              cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_key_schedule_seq.sv
// rtl/des_key_schedule_seq.sv - sequential DES round-key generator, encrypt or decrypt order
// Ports: clk, rst_n (sync active-low); key_in/mode/key_valid/key_ready key load handshake;
//        key_err parity failure pulse; subkey/subkey_idx/subkey_last/subkey_valid/subkey_ready
//        round-key output stream, one key per accepted beat.
module des_key_schedule_seq
    import des_pkg::*;
#(
    parameter int PARITY_CHECK = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key_in,
    input  logic        mode,
    input  logic        key_valid,
    output logic        key_ready,
    output logic        key_err,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  subkey_idx,
    output logic        subkey_last
);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [55:0] cd_q;
    logic [55:0] pc1_cd;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_nxt;
    logic        mode_q;
    logic        key_err_q;
    logic        parity_bad;
    logic        key_fire;
    logic        beat_fire;

    des_pc1 u_pc1 (
        .key_in (key_in),
        .cd     (pc1_cd)
    );

    des_pc2 u_pc2 (
        .cd     (cd_q),
        .subkey (subkey)
    );

    assign parity_bad = (PARITY_CHECK != 0) && !odd_parity_ok(key_in);
    assign key_fire   = key_valid && key_ready;
    assign beat_fire  = subkey_valid && subkey_ready;
    assign cnt_nxt    = cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        key_ready    = 1'b0;
        subkey_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                key_ready = 1'b1;
                if (key_valid && !parity_bad) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                subkey_valid = 1'b1;
                if (subkey_ready && (cnt_q == LAST_BEAT)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decrypt starts from the unrotated PC-1 value: the 16 encrypt rotations
    // sum to 28, so the unrotated halves already equal the K16 state, and the
    // right rotations then retrace the encrypt path backwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cd_q      <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            key_err_q <= key_fire && parity_bad;
            if (key_fire && !parity_bad) begin
                mode_q <= mode;
                cnt_q  <= '0;
                cd_q   <= mode ? pc1_cd : rot_cd(pc1_cd, 1'b0, SHIFT_SCHED[0]);
            end else if (beat_fire && (cnt_q != LAST_BEAT)) begin
                cnt_q <= cnt_nxt;
                if (mode_q) begin
                    cd_q <= rot_cd(cd_q, 1'b1, SHIFT_SCHED[LAST_BEAT - cnt_q]);
                end else begin
                    cd_q <= rot_cd(cd_q, 1'b0, SHIFT_SCHED[cnt_nxt]);
                end
            end
        end
    end

    assign key_err     = key_err_q;
    assign subkey_idx  = mode_q ? (LAST_BEAT - cnt_q) : cnt_q;
    assign subkey_last = (state_q == ST_RUN) && (cnt_q == LAST_BEAT);

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// tb/tb_des_key_schedule_seq.sv - self-checking bench for des_key_schedule_seq
module tb_des_key_schedule_seq;

    localparam logic [63:0] TEST_KEY  = 64'h133457799BBCDFF1;
    localparam logic [63:0] BAD_KEY   = 64'h133457799BBCDFF0;
    localparam logic [63:0] OTHER_KEY = 64'h0E329232EA6D0D73;

    // Published round keys K1..K16 for TEST_KEY.
    localparam logic [47:0] KTBL [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  idx;
        logic        last;
    } beat_t;

    beat_t sb[$];
    int    compared = 0;
    int    mismatched = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        mode = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic        key_err;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready = 1'b0;
    logic [3:0]  subkey_idx;
    logic        subkey_last;

    logic [63:0] p_key_in = '0;
    logic        p_key_valid = 1'b0;
    logic        p_key_ready;
    logic        p_key_err;
    logic [47:0] p_subkey;
    logic        p_subkey_valid;
    logic [3:0]  p_subkey_idx;
    logic        p_subkey_last;

    always #5 clk = ~clk;

    des_key_schedule_seq #(.PARITY_CHECK(0)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .mode(mode), .key_valid(key_valid),
        .key_ready(key_ready), .key_err(key_err), .subkey(subkey),
        .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
        .subkey_idx(subkey_idx), .subkey_last(subkey_last)
    );

    des_key_schedule_seq #(.PARITY_CHECK(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .key_in(p_key_in), .mode(1'b0), .key_valid(p_key_valid),
        .key_ready(p_key_ready), .key_err(p_key_err), .subkey(p_subkey),
        .subkey_valid(p_subkey_valid), .subkey_ready(1'b0),
        .subkey_idx(p_subkey_idx), .subkey_last(p_subkey_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic m);
        for (int i = 0; i < 16; i++) begin
            if (m) sb.push_back('{KTBL[15 - i], 4'(15 - i), i == 15});
            else   sb.push_back('{KTBL[i], 4'(i), i == 15});
        end
    endtask

    task automatic load_key(input logic [63:0] k, input logic m);
        key_in = k;
        mode = m;
        key_valid = 1'b1;
        push_expected(m);
        step();
        key_valid = 1'b0;
        key_in = '0;
        mode = ~m;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        compared++;
        if ({key_ready, subkey_valid, subkey_last, key_err, subkey, subkey_idx} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 48'h0, 4'h0}) begin
            mismatched++;
            $display("FAIL reset_outputs: rdy=%b vld=%b last=%b err=%b key=%h idx=%0d, want 1 0 0 0 0 0",
                     key_ready, subkey_valid, subkey_last, key_err, subkey, subkey_idx);
        end
        compared++;
        if ({p_key_ready, p_subkey_valid, p_key_err} !== 3'b100) begin
            mismatched++;
            $display("FAIL reset_parity_dut: rdy=%b vld=%b err=%b, want 1 0 0",
                     p_key_ready, p_subkey_valid, p_key_err);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_encrypt();
        beat_t exp;
        load_key(TEST_KEY, 1'b0);
        subkey_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = sb.pop_front();
            compared++;
            if ({subkey_valid, subkey, subkey_idx, subkey_last} !== {1'b1, exp}) begin
                mismatched++;
                $display("FAIL enc_beat %0d: vld=%b key=%h idx=%0d last=%b, want 1 %h %0d %b",
                         i, subkey_valid, subkey, subkey_idx, subkey_last, exp.key, exp.idx, exp.last);
            end
            step();
        end
        subkey_ready = 1'b0;
        compared++;
        if ({key_ready, subkey_valid} !== 2'b10) begin
            mismatched++;
            $display("FAIL enc_return_idle: rdy=%b vld=%b, want 1 0", key_ready, subkey_valid);
        end
    endtask

    task automatic test_decrypt_stall();
        beat_t       exp;
        logic [47:0] prev_key = '0;
        logic [3:0]  prev_idx = '0;
        logic        held = 1'b0;
        int          got = 0;
        int          stalls = 0;
        load_key(TEST_KEY, 1'b1);
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            if (held) begin
                compared++;
                if (subkey_valid !== 1'b1 || subkey !== prev_key || subkey_idx !== prev_idx) begin
                    mismatched++;
                    $display("FAIL stall_hold cyc %0d: vld=%b key=%h idx=%0d, want 1 %h %0d",
                             cyc, subkey_valid, subkey, subkey_idx, prev_key, prev_idx);
                end
            end
            exp = sb[0];
            compared++;
            if ({subkey_valid, subkey, subkey_idx, subkey_last} !== {1'b1, exp}) begin
                mismatched++;
                $display("FAIL dec_beat %0d: vld=%b key=%h idx=%0d last=%b, want 1 %h %0d %b",
                         got, subkey_valid, subkey, subkey_idx, subkey_last, exp.key, exp.idx, exp.last);
            end
            subkey_ready = 1'($urandom_range(0, 1));
            held = !subkey_ready;
            prev_key = subkey;
            prev_idx = subkey_idx;
            if (subkey_ready) begin
                void'(sb.pop_front());
                got++;
            end else begin
                stalls++;
            end
            step();
        end
        subkey_ready = 1'b0;
        compared++;
        if (got != 16 || subkey_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL dec_complete: beats=%0d vld=%b, want 16 0", got, subkey_valid);
        end
        sb.delete();
    endtask

    task automatic test_busy_ignore();
        beat_t exp;
        load_key(TEST_KEY, 1'b0);
        subkey_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i >= 3) begin
                key_in = OTHER_KEY;
                mode = 1'b1;
                key_valid = 1'b1;
                compared++;
                if (key_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL busy_key_ready beat %0d: got %b want 0", i, key_ready);
                end
            end
            exp = sb.pop_front();
            compared++;
            if ({subkey_valid, subkey, subkey_idx, subkey_last} !== {1'b1, exp}) begin
                mismatched++;
                $display("FAIL busy_beat %0d: vld=%b key=%h idx=%0d last=%b, want 1 %h %0d %b",
                         i, subkey_valid, subkey, subkey_idx, subkey_last, exp.key, exp.idx, exp.last);
            end
            step();
        end
        subkey_ready = 1'b0;
        key_in = TEST_KEY;
        mode = 1'b1;
        compared++;
        if ({key_ready, subkey_valid} !== 2'b10) begin
            mismatched++;
            $display("FAIL busy_release: rdy=%b vld=%b, want 1 0", key_ready, subkey_valid);
        end
        push_expected(1'b1);
        step();
        key_valid = 1'b0;
        key_in = OTHER_KEY;
        mode = 1'b0;
        subkey_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = sb.pop_front();
            compared++;
            if ({subkey_valid, subkey, subkey_idx, subkey_last} !== {1'b1, exp}) begin
                mismatched++;
                $display("FAIL next_key_beat %0d: vld=%b key=%h idx=%0d last=%b, want 1 %h %0d %b",
                         i, subkey_valid, subkey, subkey_idx, subkey_last, exp.key, exp.idx, exp.last);
            end
            step();
        end
        subkey_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        beat_t exp;
        load_key(TEST_KEY, 1'b0);
        subkey_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            void'(sb.pop_front());
            step();
        end
        exp = sb[0];
        compared++;
        if ({subkey_valid, subkey, subkey_idx} !== {1'b1, exp.key, exp.idx}) begin
            mismatched++;
            $display("FAIL pre_reset_beat7: vld=%b key=%h idx=%0d, want 1 %h %0d",
                     subkey_valid, subkey, subkey_idx, exp.key, exp.idx);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        compared++;
        if ({subkey_valid, key_ready, subkey_last, subkey, subkey_idx} !==
            {1'b0, 1'b1, 1'b0, 48'h0, 4'h0}) begin
            mismatched++;
            $display("FAIL mid_reset: vld=%b rdy=%b last=%b key=%h idx=%0d, want 0 1 0 0 0",
                     subkey_valid, key_ready, subkey_last, subkey, subkey_idx);
        end
        subkey_ready = 1'b0;
        load_key(TEST_KEY, 1'b0);
        exp = sb.pop_front();
        compared++;
        if ({subkey_valid, subkey, subkey_idx} !== {1'b1, exp.key, exp.idx}) begin
            mismatched++;
            $display("FAIL reload_k1: vld=%b key=%h idx=%0d, want 1 %h %0d",
                     subkey_valid, subkey, subkey_idx, exp.key, exp.idx);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_parity();
        p_key_in = BAD_KEY;
        p_key_valid = 1'b1;
        compared++;
        if (p_key_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL parity_ready_before: got %b want 1", p_key_ready);
        end
        step();
        p_key_valid = 1'b0;
        p_key_in = '0;
        compared++;
        if ({p_key_err, p_subkey_valid, p_key_ready} !== 3'b101) begin
            mismatched++;
            $display("FAIL parity_pulse: err=%b vld=%b rdy=%b, want 1 0 1",
                     p_key_err, p_subkey_valid, p_key_ready);
        end
        step();
        compared++;
        if ({p_key_err, p_subkey_valid, p_key_ready} !== 3'b001) begin
            mismatched++;
            $display("FAIL parity_pulse_end: err=%b vld=%b rdy=%b, want 0 0 1",
                     p_key_err, p_subkey_valid, p_key_ready);
        end
        p_key_in = TEST_KEY;
        p_key_valid = 1'b1;
        step();
        p_key_valid = 1'b0;
        compared++;
        if ({p_key_err, p_subkey_valid, p_subkey, p_subkey_idx} !== {1'b0, 1'b1, KTBL[0], 4'd0}) begin
            mismatched++;
            $display("FAIL parity_good_key: err=%b vld=%b key=%h idx=%0d, want 0 1 %h 0",
                     p_key_err, p_subkey_valid, p_subkey, p_subkey_idx, KTBL[0]);
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt_stall();
        test_busy_ignore();
        test_reset_mid();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
